// File: rtl/friscv_pkg.sv
// Shared friscv constants and types: bus width, data-memory MMIO map,
// store sizes and status/control bit positions.
package friscv_pkg;

  localparam int ARCH = 32;

  localparam logic [31:0] MMIO_BASE = 32'h8000_0000;

  localparam logic [5:0] CONSOLE_TX_OFS     = 6'h00;
  localparam logic [5:0] CONSOLE_STATUS_OFS = 6'h04;
  localparam logic [5:0] MTIME_LO_OFS       = 6'h08;
  localparam logic [5:0] MTIME_HI_OFS       = 6'h0C;
  localparam logic [5:0] MTIMECMP_LO_OFS    = 6'h10;
  localparam logic [5:0] MTIMECMP_HI_OFS    = 6'h14;
  localparam logic [5:0] TIMER_CTRL_OFS     = 6'h18;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } store_size_t;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 8;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_PEND_BIT = 1;

  function automatic logic store_aligned(input store_size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: store_aligned = 1'b1;
      SZ_HALF: store_aligned = (lo[0] == 1'b0);
      SZ_WORD: store_aligned = (lo == 2'b00);
      default: store_aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input store_size_t sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: lane_mask = 4'b0001 << lo;
      SZ_HALF: lane_mask = 4'b0011 << lo;
      SZ_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/friscv_data_mem_sync_fifo.sv
// Generic synchronous FIFO with occupancy count; a push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [PW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == '0);
  assign full      = (count_r == (PW+1)'(DEPTH));
  assign count     = count_r;
  assign pop_data  = mem_r[rd_ptr_r];
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/friscv_data_mem.sv
// Data-side memory responder: word RAM, console TX FIFO and 64-bit machine
// timer behind a small MMIO window, with combinational read data.
module friscv_data_mem
  import friscv_pkg::*;
#(
  parameter int          ARCH          = friscv_pkg::ARCH,
  parameter int          DMEM_DEPTH    = 1024,
  parameter int          TX_FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE     = friscv_pkg::MMIO_BASE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ARCH-1:0] addr_in,
  input  logic [ARCH-1:0] w_data_in,
  input  logic            mem_write_in,
  input  logic [1:0]      store_size_in,
  output logic [ARCH-1:0] r_data_out,
  output logic [7:0]      tx_data_out,
  output logic            tx_valid_out,
  input  logic            tx_ready_in,
  output logic            timer_irq_out,
  output logic            bus_err_out
);

  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam int CW  = $clog2(TX_FIFO_DEPTH) + 1;
  localparam logic [ARCH-1:0] MB = ARCH'(MMIO_BASE);

  logic [ARCH-1:0] ram_r [DMEM_DEPTH];
  logic [DAW-1:0]  ram_idx_s;
  logic            is_ram_s;
  logic            is_mmio_s;
  logic [5:0]      ofs_s;
  store_size_t     size_s;
  logic [ARCH-1:0] wdata_sh_s;
  logic [3:0]      ram_mask_s;

  logic wr_tx_s, wr_status_s, wr_mtime_lo_s, wr_mtime_hi_s;
  logic wr_cmp_lo_s, wr_cmp_hi_s, wr_ctrl_s, err_set_s, snap_rd_s;

  logic            fifo_full_s, fifo_empty_s, pop_s, ovf_set_s;
  logic [CW-1:0]   fifo_count_s;
  logic            ovf_r, err_r, en_r, pend_r, pend_nxt_s, tmr_hit_s;
  logic [63:0]     mtime_r, mtime_nxt_s, cmp_r;
  logic [31:0]     snap_r;
  logic [ARCH-1:0] status_s;

  assign ram_idx_s  = addr_in[DAW+1:2];
  assign is_ram_s   = (addr_in[ARCH-1:DAW+2] == '0);
  assign is_mmio_s  = (addr_in[ARCH-1:6] == MB[ARCH-1:6]);
  assign ofs_s      = {addr_in[5:2], 2'b00};
  assign size_s     = store_size_t'(store_size_in);
  assign wdata_sh_s = w_data_in << {addr_in[1:0], 3'b000};

  // Store decode: RAM lane mask, MMIO register strobes and bus-error detection.
  always_comb begin
    ram_mask_s    = 4'b0000;
    wr_tx_s       = 1'b0;
    wr_status_s   = 1'b0;
    wr_mtime_lo_s = 1'b0;
    wr_mtime_hi_s = 1'b0;
    wr_cmp_lo_s   = 1'b0;
    wr_cmp_hi_s   = 1'b0;
    wr_ctrl_s     = 1'b0;
    err_set_s     = 1'b0;
    snap_rd_s     = 1'b0;
    if (mem_write_in) begin
      if (is_ram_s) begin
        if (store_aligned(size_s, addr_in[1:0])) ram_mask_s = lane_mask(size_s, addr_in[1:0]);
        else                                     err_set_s  = 1'b1;
      end else if (is_mmio_s && size_s == SZ_WORD && addr_in[1:0] == 2'b00) begin
        case (ofs_s)
          CONSOLE_TX_OFS:     wr_tx_s       = 1'b1;
          CONSOLE_STATUS_OFS: wr_status_s   = 1'b1;
          MTIME_LO_OFS:       wr_mtime_lo_s = 1'b1;
          MTIME_HI_OFS:       wr_mtime_hi_s = 1'b1;
          MTIMECMP_LO_OFS:    wr_cmp_lo_s   = 1'b1;
          MTIMECMP_HI_OFS:    wr_cmp_hi_s   = 1'b1;
          TIMER_CTRL_OFS:     wr_ctrl_s     = 1'b1;
          default:            err_set_s     = 1'b1;
        endcase
      end else begin
        err_set_s = 1'b1;
      end
    end else begin
      snap_rd_s = is_mmio_s && (ofs_s == MTIME_LO_OFS);
    end
  end

  // RAM byte-lane writes; contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_mask_s[b]) ram_r[ram_idx_s][8*b +: 8] <= wdata_sh_s[8*b +: 8];
    end
  end

  assign pop_s        = tx_valid_out & tx_ready_in;
  assign tx_valid_out = ~fifo_empty_s;
  assign ovf_set_s    = wr_tx_s & fifo_full_s & ~pop_s;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_tx_s),
    .push_data (w_data_in[7:0]),
    .pop       (pop_s),
    .pop_data  (tx_data_out),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Next mtime: a software load of either half takes priority over counting.
  always_comb begin
    mtime_nxt_s = mtime_r;
    if (wr_mtime_lo_s)      mtime_nxt_s[31:0]  = w_data_in[31:0];
    else if (wr_mtime_hi_s) mtime_nxt_s[63:32] = w_data_in[31:0];
    else if (en_r)          mtime_nxt_s        = mtime_r + 64'd1;
    else                    mtime_nxt_s        = mtime_r;
  end

  assign tmr_hit_s  = en_r & (mtime_r >= cmp_r);
  assign pend_nxt_s = tmr_hit_s | (pend_r & ~(wr_ctrl_s & w_data_in[CTRL_PEND_BIT]));

  // Timer, console overflow, bus error and MTIME_HI snapshot state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime_r <= 64'd0;
      cmp_r   <= {64{1'b1}};
      en_r    <= 1'b0;
      pend_r  <= 1'b0;
      ovf_r   <= 1'b0;
      err_r   <= 1'b0;
      snap_r  <= 32'd0;
    end else begin
      mtime_r <= mtime_nxt_s;
      if (wr_cmp_lo_s) cmp_r[31:0]  <= w_data_in[31:0];
      if (wr_cmp_hi_s) cmp_r[63:32] <= w_data_in[31:0];
      if (wr_ctrl_s)   en_r         <= w_data_in[CTRL_EN_BIT];
      pend_r <= pend_nxt_s;
      if (ovf_set_s)        ovf_r <= 1'b1;
      else if (wr_status_s) ovf_r <= 1'b0;
      if (err_set_s)   err_r  <= 1'b1;
      if (snap_rd_s)   snap_r <= mtime_r[63:32];
    end
  end

  assign timer_irq_out = pend_r;
  assign bus_err_out   = err_r;

  // Console status word assembly.
  always_comb begin
    status_s                          = '0;
    status_s[STAT_EMPTY_BIT]          = fifo_empty_s;
    status_s[STAT_FULL_BIT]           = fifo_full_s;
    status_s[STAT_OVF_BIT]            = ovf_r;
    status_s[STAT_COUNT_LSB +: CW]    = fifo_count_s;
  end

  // Combinational read mux; CONSOLE_TX and unmapped locations read as zero.
  always_comb begin
    r_data_out = '0;
    if (is_ram_s) begin
      r_data_out = ram_r[ram_idx_s];
    end else if (is_mmio_s) begin
      case (ofs_s)
        CONSOLE_STATUS_OFS: r_data_out = status_s;
        MTIME_LO_OFS:       r_data_out = mtime_r[31:0];
        MTIME_HI_OFS:       r_data_out = snap_r;
        MTIMECMP_LO_OFS:    r_data_out = cmp_r[31:0];
        MTIMECMP_HI_OFS:    r_data_out = cmp_r[63:32];
        TIMER_CTRL_OFS: begin
          r_data_out[CTRL_EN_BIT]   = en_r;
          r_data_out[CTRL_PEND_BIT] = pend_r;
        end
        default:            r_data_out = '0;
      endcase
    end else begin
      r_data_out = '0;
    end
  end

endmodule
